// File: rtl/ads_frame_packer.sv
// Packs framed 16-bit ADS8568 samples into 64-bit beats and writes each whole frame as one AXI4 INCR burst.
// Optional ADS_PACK_TIMESTAMP_EN prefixes every burst with a {seq, ts} header beat.
module ads_frame_packer #(
  parameter int unsigned SAMPLES_PER_FRAME = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned C_AXI_ID_WIDTH = 4,
  parameter int unsigned C_AXI_ADDR_WIDTH = 32,
  parameter logic [C_AXI_ADDR_WIDTH-1:0] C_ADDR_AD2ETH = '0,
  parameter int unsigned ADDR_WRAP_FRAMES = 4
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        smp_valid,
  input  logic [15:0]                 smp_data,
  input  logic                        smp_last,
  input  logic                        maxi_wready,
  output logic [C_AXI_ID_WIDTH-1:0]   maxi_wid,
  output logic [C_AXI_ADDR_WIDTH-1:0] maxi_waddr,
  output logic [7:0]                  maxi_wlen,
  output logic [2:0]                  maxi_wsize,
  output logic [1:0]                  maxi_wburst,
  output logic                        maxi_wvalid,
  input  logic                        maxi_wd_wready,
  output logic [63:0]                 maxi_wd_wdata,
  output logic [7:0]                  maxi_wd_wstrb,
  output logic                        maxi_wd_wlast,
  output logic                        maxi_wd_wvalid,
  input  logic [1:0]                  maxi_wb_bresp,
  input  logic                        maxi_wb_bvalid,
  output logic                        maxi_wb_bready,
  output logic [15:0]                 drop_cnt,
  output logic [15:0]                 err_cnt
);
  localparam int unsigned BEATS = SAMPLES_PER_FRAME / 4;
  localparam int unsigned FA = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = FA + 1;
  localparam int unsigned IW = $clog2(SAMPLES_PER_FRAME);
  localparam int unsigned SW = (ADDR_WRAP_FRAMES > 1) ? $clog2(ADDR_WRAP_FRAMES) : 1;
  localparam int unsigned AW = C_AXI_ADDR_WIDTH;
`ifdef ADS_PACK_TIMESTAMP_EN
  localparam int unsigned HDR = 1;
`else
  localparam int unsigned HDR = 0;
`endif
  localparam int unsigned BURST = BEATS + HDR;
  localparam int unsigned STRIDE = BURST * 8;
  localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLES_PER_FRAME - 1);

  typedef enum logic [1:0] {IN_RX, IN_DROP, IN_SKIP} in_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_AW, WR_W, WR_B} wr_state_t;

  in_state_t in_state, in_next;
  wr_state_t wr_state, wr_next;

  logic [63:0]   mem [FIFO_DEPTH];
  logic [IW-1:0] idx;
  logic [15:0]   lane0, lane1, lane2;
  logic [PW-1:0] wptr_spec, wptr_commit, rptr, rptr_n, frames_ready, used;
  logic [PW:0]   free;
  logic          no_room, accept, commit, bad, drop_done, beat_wr;
  logic          b_done, b_err, data_hs;
  logic [16:0]   err_sum;
  logic [SW-1:0] slot, slot_n;
  logic [7:0]    beat, beat_n;
  logic          aw_valid_n, wd_valid_n, wd_last_n, bready_n;
  logic [AW-1:0] waddr_n;
  logic [63:0]   wd_data_n;

  assign maxi_wid      = '0;
  assign maxi_wlen     = 8'(BURST - 1);
  assign maxi_wsize    = 3'b011;
  assign maxi_wburst   = 2'b01;
  assign maxi_wd_wstrb = 8'hFF;

  // Space check counts only the read pointer so a draining frame frees room beat by beat.
  assign used    = wptr_spec - rptr;
  assign free    = (PW+1)'(FIFO_DEPTH) - {1'b0, used};
  assign no_room = free < (PW+1)'(BEATS);
  assign beat_wr = accept && (idx[1:0] == 2'd3);
  assign err_sum = {1'b0, err_cnt} + 17'(bad) + 17'(b_err);

  // Input framing: admit, drop or discard whole frames.
  always_comb begin
    in_next   = in_state;
    accept    = 1'b0;
    commit    = 1'b0;
    bad       = 1'b0;
    drop_done = 1'b0;
    if (smp_valid) begin
      case (in_state)
        IN_RX: begin
          if (idx == '0 && no_room) begin
            if (smp_last) drop_done = 1'b1;
            else          in_next   = IN_DROP;
          end else begin
            accept = 1'b1;
            if (smp_last) begin
              if (idx == LAST_IDX) commit = 1'b1;
              else                 bad    = 1'b1;
            end else if (idx == LAST_IDX) begin
              bad     = 1'b1;
              in_next = IN_SKIP;
            end
          end
        end
        IN_DROP: if (smp_last) begin
          drop_done = 1'b1;
          in_next   = IN_RX;
        end
        IN_SKIP: if (smp_last) in_next = IN_RX;
        default: in_next = IN_RX;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (beat_wr) mem[wptr_spec[FA-1:0]] <= {smp_data, lane2, lane1, lane0};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      in_state     <= IN_RX;
      idx          <= '0;
      lane0        <= '0;
      lane1        <= '0;
      lane2        <= '0;
      wptr_spec    <= '0;
      wptr_commit  <= '0;
      frames_ready <= '0;
      drop_cnt     <= '0;
      err_cnt      <= '0;
    end else begin
      in_state <= in_next;
      if (accept) begin
        idx <= (smp_last || idx == LAST_IDX) ? '0 : idx + IW'(1);
        case (idx[1:0])
          2'd0:    lane0 <= smp_data;
          2'd1:    lane1 <= smp_data;
          2'd2:    lane2 <= smp_data;
          default: ;
        endcase
      end
      if (bad)          wptr_spec <= wptr_commit;
      else if (beat_wr) wptr_spec <= wptr_spec + PW'(1);
      if (commit) wptr_commit <= wptr_spec + PW'(1);
      frames_ready <= frames_ready + PW'(commit) - PW'(b_done);
      if (drop_done && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

`ifdef ADS_PACK_TIMESTAMP_EN
  // Per-frame header side FIFO, filled at commit and consumed when a burst completes.
  logic [47:0]   ts_cnt;
  logic [15:0]   seq;
  logic [63:0]   ts_mem [ADDR_WRAP_FRAMES];
  logic [SW-1:0] ts_wptr, ts_rptr;

  always_ff @(posedge sys_clk) begin
    if (commit) ts_mem[ts_wptr] <= {seq, ts_cnt};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ts_cnt  <= '0;
      seq     <= '0;
      ts_wptr <= '0;
      ts_rptr <= '0;
    end else begin
      ts_cnt <= ts_cnt + 48'd1;
      if (commit) begin
        seq     <= seq + 16'd1;
        ts_wptr <= (ts_wptr == SW'(ADDR_WRAP_FRAMES - 1)) ? '0 : ts_wptr + SW'(1);
      end
      if (b_done) ts_rptr <= (ts_rptr == SW'(ADDR_WRAP_FRAMES - 1)) ? '0 : ts_rptr + SW'(1);
    end
  end
  assign data_hs = (beat != 8'd0);
`else
  assign data_hs = 1'b1;
`endif

  // Write FSM: next state and next values of every registered AXI output.
  always_comb begin
    wr_next    = wr_state;
    aw_valid_n = maxi_wvalid;
    waddr_n    = maxi_waddr;
    wd_valid_n = maxi_wd_wvalid;
    wd_last_n  = maxi_wd_wlast;
    wd_data_n  = maxi_wd_wdata;
    bready_n   = maxi_wb_bready;
    rptr_n     = rptr;
    beat_n     = beat;
    slot_n     = slot;
    b_done     = 1'b0;
    b_err      = 1'b0;
    case (wr_state)
      WR_IDLE: if (frames_ready != '0) begin
        wr_next    = WR_AW;
        aw_valid_n = 1'b1;
        waddr_n    = C_ADDR_AD2ETH + AW'(slot) * AW'(STRIDE);
      end
      WR_AW: if (maxi_wready) begin
        wr_next    = WR_W;
        aw_valid_n = 1'b0;
        wd_valid_n = 1'b1;
        wd_last_n  = (BURST == 1);
        beat_n     = '0;
`ifdef ADS_PACK_TIMESTAMP_EN
        wd_data_n  = ts_mem[ts_rptr];
`else
        wd_data_n  = mem[rptr[FA-1:0]];
`endif
      end
      WR_W: if (maxi_wd_wready) begin
        rptr_n = rptr + PW'(data_hs);
        if (beat == 8'(BURST - 1)) begin
          wr_next    = WR_B;
          wd_valid_n = 1'b0;
          wd_last_n  = 1'b0;
          bready_n   = 1'b1;
        end else begin
          beat_n    = beat + 8'd1;
          wd_last_n = (beat + 8'd1 == 8'(BURST - 1));
          wd_data_n = mem[rptr_n[FA-1:0]];
        end
      end
      WR_B: if (maxi_wb_bvalid) begin
        wr_next  = WR_IDLE;
        bready_n = 1'b0;
        b_done   = 1'b1;
        b_err    = (maxi_wb_bresp != 2'b00);
        slot_n   = (slot == SW'(ADDR_WRAP_FRAMES - 1)) ? '0 : slot + SW'(1);
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_state       <= WR_IDLE;
      maxi_wvalid    <= 1'b0;
      maxi_waddr     <= '0;
      maxi_wd_wvalid <= 1'b0;
      maxi_wd_wlast  <= 1'b0;
      maxi_wd_wdata  <= '0;
      maxi_wb_bready <= 1'b0;
      rptr           <= '0;
      beat           <= '0;
      slot           <= '0;
    end else begin
      wr_state       <= wr_next;
      maxi_wvalid    <= aw_valid_n;
      maxi_waddr     <= waddr_n;
      maxi_wd_wvalid <= wd_valid_n;
      maxi_wd_wlast  <= wd_last_n;
      maxi_wd_wdata  <= wd_data_n;
      maxi_wb_bready <= bready_n;
      rptr           <= rptr_n;
      beat           <= beat_n;
      slot           <= slot_n;
    end
  end
endmodule

// File: tb/tb_ads_frame_packer.sv
// Directed bench for ads_frame_packer: packing, address ring, drops, malformed frames, AXI stalls, reset.
module tb_ads_frame_packer;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        smp_valid, smp_last;
  logic [15:0] smp_data;
  logic        maxi_wready;
  logic [3:0]  maxi_wid;
  logic [31:0] maxi_waddr;
  logic [7:0]  maxi_wlen;
  logic [2:0]  maxi_wsize;
  logic [1:0]  maxi_wburst;
  logic        maxi_wvalid;
  logic        maxi_wd_wready;
  logic [63:0] maxi_wd_wdata;
  logic [7:0]  maxi_wd_wstrb;
  logic        maxi_wd_wlast, maxi_wd_wvalid;
  logic [1:0]  maxi_wb_bresp;
  logic        maxi_wb_bvalid, maxi_wb_bready;
  logic [15:0] drop_cnt, err_cnt;

  always #5 sys_clk = ~sys_clk;

  ads_frame_packer dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_last(smp_last),
    .maxi_wready(maxi_wready), .maxi_wid(maxi_wid), .maxi_waddr(maxi_waddr),
    .maxi_wlen(maxi_wlen), .maxi_wsize(maxi_wsize), .maxi_wburst(maxi_wburst),
    .maxi_wvalid(maxi_wvalid), .maxi_wd_wready(maxi_wd_wready),
    .maxi_wd_wdata(maxi_wd_wdata), .maxi_wd_wstrb(maxi_wd_wstrb),
    .maxi_wd_wlast(maxi_wd_wlast), .maxi_wd_wvalid(maxi_wd_wvalid),
    .maxi_wb_bresp(maxi_wb_bresp), .maxi_wb_bvalid(maxi_wb_bvalid),
    .maxi_wb_bready(maxi_wb_bready), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
  );

  int          tests = 0;
  int          fails = 0;
  int          b_cnt = 0;
  logic [31:0] aw_q[$];
  logic [63:0] w_q[$];
  logic        l_q[$];
  logic        aw_hold = 1'b0;
  logic [31:0] hold_addr = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_beat(input logic [15:0] base, input int b);
    logic [15:0] s;
    s = base + 16'(4 * b);
    return {s + 16'd3, s + 16'd2, s + 16'd1, s};
  endfunction

  // Channel monitor, sampled on the falling edge between handshakes.
  initial forever begin
    @(negedge sys_clk);
    if (!sys_rst_n) aw_hold = 1'b0;
    else begin
      if (aw_hold) begin
        check("aw_valid_stable", 64'(maxi_wvalid), 64'd1);
        check("aw_addr_stable", 64'(maxi_waddr), 64'(hold_addr));
      end
      if (maxi_wvalid && maxi_wready) aw_q.push_back(maxi_waddr);
      if (maxi_wd_wvalid && maxi_wd_wready) begin
        w_q.push_back(maxi_wd_wdata);
        l_q.push_back(maxi_wd_wlast);
      end
      if (maxi_wb_bready && maxi_wb_bvalid) b_cnt++;
      aw_hold   = maxi_wvalid && !maxi_wready;
      hold_addr = maxi_waddr;
    end
  end

  task automatic reset_dut();
    sys_rst_n = 1'b0;
    smp_valid = 1'b0; smp_last = 1'b0; smp_data = '0;
    maxi_wready = 1'b1; maxi_wd_wready = 1'b1;
    maxi_wb_bvalid = 1'b1; maxi_wb_bresp = 2'b00;
    repeat (2) @(posedge sys_clk);
    aw_q.delete(); w_q.delete(); l_q.delete(); b_cnt = 0;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic send_frame(input logic [15:0] base, input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk); #1;
      smp_valid = 1'b1;
      smp_data  = base + 16'(i);
      smp_last  = (i == last_at);
    end
    @(posedge sys_clk); #1;
    smp_valid = 1'b0;
    smp_last  = 1'b0;
  endtask

  task automatic wait_bursts(input int target, input int budget);
    int n;
    n = 0;
    while (b_cnt < target && n < budget) begin
      @(posedge sys_clk);
      n++;
    end
    check("burst_count", 64'(b_cnt), 64'(target));
  endtask

  task automatic check_frame(input int burst, input logic [15:0] base);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("data_f%0d_b%0d", burst, b), w_q[burst*4+b], exp_beat(base, b));
      check($sformatf("wlast_f%0d_b%0d", burst, b), 64'(l_q[burst*4+b]), 64'(b == 3));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_dut();
    check("rst_awvalid", 64'(maxi_wvalid), 64'd0);
    check("rst_wvalid", 64'(maxi_wd_wvalid), 64'd0);
    check("rst_wlast", 64'(maxi_wd_wlast), 64'd0);
    check("rst_bready", 64'(maxi_wb_bready), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_err", 64'(err_cnt), 64'd0);
    check("wlen", 64'(maxi_wlen), 64'd3);
    check("wstrb", 64'(maxi_wd_wstrb), 64'hFF);
    check("wsize", 64'(maxi_wsize), 64'd3);
    check("wburst", 64'(maxi_wburst), 64'd1);
    check("wid", 64'(maxi_wid), 64'd0);

    // Single frame 0x0001..0x0010.
    send_frame(16'h0001, 16, 15);
    wait_bursts(1, 100);
    repeat (3) @(posedge sys_clk);
    check("t1_addr", 64'(aw_q[0]), 64'h0);
    check("t1_beats", 64'(w_q.size()), 64'd4);
    check("t1_beat0", w_q[0], 64'h0004_0003_0002_0001);
    check("t1_beat3", w_q[3], 64'h0010_000F_000E_000D);
    check_frame(0, 16'h0001);
    check("t1_err", 64'(err_cnt), 64'd0);

    // Five frames: address ring wraps after four slots.
    reset_dut();
    for (int f = 0; f < 5; f++) send_frame(16'(f * 16 + 1), 16, 15);
    wait_bursts(5, 300);
    repeat (3) @(posedge sys_clk);
    check("t2_aw_count", 64'(aw_q.size()), 64'd5);
    check("t2_addr0", 64'(aw_q[0]), 64'h00);
    check("t2_addr1", 64'(aw_q[1]), 64'h20);
    check("t2_addr2", 64'(aw_q[2]), 64'h40);
    check("t2_addr3", 64'(aw_q[3]), 64'h60);
    check("t2_addr4", 64'(aw_q[4]), 64'h00);
    for (int f = 0; f < 5; f++) check_frame(f, 16'(f * 16 + 1));
    check("t2_drop", 64'(drop_cnt), 64'd0);

    // W channel stalled: fifth frame dropped, four intact bursts after release.
    reset_dut();
    maxi_wd_wready = 1'b0;
    for (int f = 0; f < 5; f++) send_frame(16'(f * 16 + 1), 16, 15);
    repeat (5) @(posedge sys_clk);
    check("t3_drop", 64'(drop_cnt), 64'd1);
    check("t3_no_bursts", 64'(b_cnt), 64'd0);
    #1 maxi_wd_wready = 1'b1;
    wait_bursts(4, 300);
    repeat (30) @(posedge sys_clk);
    check("t3_exact_bursts", 64'(b_cnt), 64'd4);
    check("t3_beats", 64'(w_q.size()), 64'd16);
    check("t3_addr3", 64'(aw_q[3]), 64'h60);
    for (int f = 0; f < 4; f++) check_frame(f, 16'(f * 16 + 1));

    // Early smp_last, then overlong frame, each followed by a good frame.
    reset_dut();
    send_frame(16'h0100, 9, 8);
    repeat (20) @(posedge sys_clk);
    check("t4_err", 64'(err_cnt), 64'd1);
    check("t4_no_aw", 64'(aw_q.size()), 64'd0);
    send_frame(16'h0201, 16, 15);
    wait_bursts(1, 100);
    check("t4_addr", 64'(aw_q[0]), 64'h00);
    check_frame(0, 16'h0201);
    send_frame(16'h0300, 19, 18);
    repeat (20) @(posedge sys_clk);
    check("t4b_err", 64'(err_cnt), 64'd2);
    check("t4b_no_aw", 64'(aw_q.size()), 64'd1);
    send_frame(16'h0401, 16, 15);
    wait_bursts(2, 100);
    check("t4b_addr", 64'(aw_q[1]), 64'h20);
    check_frame(1, 16'h0401);

    // AW ready delayed 7 cycles, first response SLVERR.
    reset_dut();
    maxi_wready = 1'b0;
    maxi_wb_bresp = 2'b10;
    send_frame(16'h0001, 16, 15);
    for (int n = 0; n < 20 && !maxi_wvalid; n++) @(posedge sys_clk);
    check("t5_aw_seen", 64'(maxi_wvalid), 64'd1);
    repeat (7) @(posedge sys_clk);
    #1 maxi_wready = 1'b1;
    wait_bursts(1, 100);
    #1 maxi_wb_bresp = 2'b00;
    send_frame(16'h0011, 16, 15);
    wait_bursts(2, 100);
    repeat (3) @(posedge sys_clk);
    check("t5_err", 64'(err_cnt), 64'd1);
    check("t5_addr0", 64'(aw_q[0]), 64'h00);
    check("t5_addr1", 64'(aw_q[1]), 64'h20);
    check_frame(0, 16'h0001);
    check_frame(1, 16'h0011);

    // Reset while beat 2 is on the W channel.
    reset_dut();
    send_frame(16'h0001, 16, 15);
    for (int n = 0; n < 50; n++) begin
      @(posedge sys_clk); #2;
      if (w_q.size() >= 2) break;
    end
    check("t6_beat2_valid", 64'(maxi_wd_wvalid), 64'd1);
    check("t6_beat2_data", maxi_wd_wdata, 64'h000C_000B_000A_0009);
    sys_rst_n = 1'b0;
    #1;
    check("t6_awvalid", 64'(maxi_wvalid), 64'd0);
    check("t6_wvalid", 64'(maxi_wd_wvalid), 64'd0);
    check("t6_wlast", 64'(maxi_wd_wlast), 64'd0);
    check("t6_bready", 64'(maxi_wb_bready), 64'd0);
    check("t6_err", 64'(err_cnt), 64'd0);
    check("t6_drop", 64'(drop_cnt), 64'd0);
    reset_dut();
    send_frame(16'h0501, 16, 15);
    wait_bursts(1, 100);
    check("t6_addr", 64'(aw_q[0]), 64'h00);
    check("t6_beats", 64'(w_q.size()), 64'd4);
    check_frame(0, 16'h0501);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
